// File: rtl/brcunit.sv
// Branch resolution unit: evaluates branch/jump conditions, latches the target and issues a
// registered redirect once the delay slot is fetched. Build macro BRC_LIKELY_EN enables BEQL/BNEL.
module brcunit #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        br_valid,
   input  logic [3:0]  br_op,
   input  logic [31:0] source_a,
   input  logic [31:0] source_b,
   input  logic [31:0] pc_id,
   input  logic [15:0] imm16,
   input  logic [25:0] index26,
   input  logic        ds_fetched,
   input  logic        flush,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic        link_en,
   output logic [31:0] link_addr,
   output logic        stall_req,
   output logic        addr_err,
   output logic [31:0] bad_addr,
   output logic        nullify_ds
);

   localparam int unsigned XLEN = 32;

   localparam logic [3:0] OP_BEQ    = 4'd0;
   localparam logic [3:0] OP_BNE    = 4'd1;
   localparam logic [3:0] OP_BLEZ   = 4'd2;
   localparam logic [3:0] OP_BGTZ   = 4'd3;
   localparam logic [3:0] OP_BLTZ   = 4'd4;
   localparam logic [3:0] OP_BGEZ   = 4'd5;
   localparam logic [3:0] OP_BLTZAL = 4'd6;
   localparam logic [3:0] OP_BGEZAL = 4'd7;
   localparam logic [3:0] OP_J      = 4'd8;
   localparam logic [3:0] OP_JAL    = 4'd9;
   localparam logic [3:0] OP_JR     = 4'd10;
   localparam logic [3:0] OP_JALR   = 4'd11;
   localparam logic [3:0] OP_BEQL   = 4'd12;
   localparam logic [3:0] OP_BNEL   = 4'd13;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT_DS = 2'd1,
      S_ISSUE   = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   target_q, target_d;
   logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
   logic [XLEN-1:0]   bad_addr_q, bad_addr_d;
   logic              redirect_q, redirect_d;
   logic              stall_q, stall_d;
   logic              addr_err_q, addr_err_d;
   logic              nullify_q, nullify_d;

   logic [XLEN-1:0]   pc_plus4_c;
   logic [XLEN-1:0]   br_tgt_c;
   logic [XLEN-1:0]   jmp_tgt_c;
   logic [XLEN-1:0]   tgt_c;
   logic              taken_c;
   logic              is_jreg_c;
   logic              likely_nt_c;
   logic              a_neg_c;
   logic              a_zero_c;
   logic              a_eq_b_c;

   assign pc_plus4_c = pc_id + XLEN'(4);
   assign br_tgt_c   = pc_plus4_c + {{14{imm16[15]}}, imm16, 2'b00};
   assign jmp_tgt_c  = {pc_plus4_c[31:28], index26, 2'b00};
   assign a_neg_c    = source_a[XLEN-1];
   assign a_zero_c   = (source_a == '0);
   assign a_eq_b_c   = (source_a == source_b);

   // Condition and target decode; reserved and disabled opcodes resolve as not taken.
   always_comb begin
      taken_c     = 1'b0;
      is_jreg_c   = 1'b0;
      tgt_c       = br_tgt_c;
      likely_nt_c = 1'b0;
      case (br_op)
         OP_BEQ:               taken_c = a_eq_b_c;
         OP_BNE:               taken_c = !a_eq_b_c;
         OP_BLEZ:              taken_c = a_neg_c || a_zero_c;
         OP_BGTZ:              taken_c = !a_neg_c && !a_zero_c;
         OP_BLTZ, OP_BLTZAL:   taken_c = a_neg_c;
         OP_BGEZ, OP_BGEZAL:   taken_c = !a_neg_c;
         OP_J, OP_JAL: begin
            taken_c = 1'b1;
            tgt_c   = jmp_tgt_c;
         end
         OP_JR, OP_JALR: begin
            taken_c   = 1'b1;
            is_jreg_c = 1'b1;
            tgt_c     = source_a;
         end
`ifdef BRC_LIKELY_EN
         OP_BEQL: begin
            taken_c     = a_eq_b_c;
            likely_nt_c = !a_eq_b_c;
         end
         OP_BNEL: begin
            taken_c     = !a_eq_b_c;
            likely_nt_c = a_eq_b_c;
         end
`endif
         default:              taken_c = 1'b0;
      endcase
   end

   assign link_en   = br_valid && ((br_op == OP_BLTZAL) || (br_op == OP_BGEZAL) ||
                                   (br_op == OP_JAL)    || (br_op == OP_JALR));
   assign link_addr = pc_id + XLEN'(8);

   // Next-state and registered-output logic; flush overrides every other event.
   always_comb begin
      state_d       = state_q;
      target_d      = target_q;
      redirect_pc_d = redirect_pc_q;
      bad_addr_d    = bad_addr_q;
      addr_err_d    = 1'b0;
      nullify_d     = 1'b0;
      if (flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (br_valid) begin
                  if (taken_c && (tgt_c[1:0] == 2'b00)) begin
                     target_d = tgt_c;
                     if (ds_fetched) begin
                        state_d       = S_ISSUE;
                        redirect_pc_d = tgt_c;
                     end else begin
                        state_d = S_WAIT_DS;
                     end
                  end else if (is_jreg_c && (tgt_c[1:0] != 2'b00)) begin
                     addr_err_d = 1'b1;
                     bad_addr_d = tgt_c;
                  end
                  nullify_d = likely_nt_c;
               end
            end
            S_WAIT_DS: begin
               if (ds_fetched) begin
                  state_d       = S_ISSUE;
                  redirect_pc_d = target_q;
               end
            end
            S_ISSUE:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
         endcase
      end
      redirect_d = (state_d == S_ISSUE);
      stall_d    = (state_d == S_WAIT_DS);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         target_q      <= RESET_PC;
         redirect_pc_q <= RESET_PC;
         bad_addr_q    <= '0;
         redirect_q    <= 1'b0;
         stall_q       <= 1'b0;
         addr_err_q    <= 1'b0;
         nullify_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         target_q      <= target_d;
         redirect_pc_q <= redirect_pc_d;
         bad_addr_q    <= bad_addr_d;
         redirect_q    <= redirect_d;
         stall_q       <= stall_d;
         addr_err_q    <= addr_err_d;
         nullify_q     <= nullify_d;
      end
   end

   assign redirect    = redirect_q;
   assign redirect_pc = redirect_pc_q;
   assign stall_req   = stall_q;
   assign addr_err    = addr_err_q;
   assign bad_addr    = bad_addr_q;
   assign nullify_ds  = nullify_q;

endmodule

// File: tb/tb_brcunit.sv
// Directed bench for brcunit: per-cycle expected outputs are queued as stimulus is driven and
// compared as each clock edge produces them. Follows BRC_LIKELY_EN the same way as the design.
module tb_brcunit;

   localparam logic [31:0] RST_PC = 32'hBFC0_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        br_valid;
   logic [3:0]  br_op;
   logic [31:0] source_a;
   logic [31:0] source_b;
   logic [31:0] pc_id;
   logic [15:0] imm16;
   logic [25:0] index26;
   logic        ds_fetched;
   logic        flush;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        link_en;
   logic [31:0] link_addr;
   logic        stall_req;
   logic        addr_err;
   logic [31:0] bad_addr;
   logic        nullify_ds;

   always #5 clk = ~clk;

   brcunit #(.RESET_PC(RST_PC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .br_valid    (br_valid),
      .br_op       (br_op),
      .source_a    (source_a),
      .source_b    (source_b),
      .pc_id       (pc_id),
      .imm16       (imm16),
      .index26     (index26),
      .ds_fetched  (ds_fetched),
      .flush       (flush),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .link_en     (link_en),
      .link_addr   (link_addr),
      .stall_req   (stall_req),
      .addr_err    (addr_err),
      .bad_addr    (bad_addr),
      .nullify_ds  (nullify_ds)
   );

   typedef struct packed {
      logic        redirect;
      logic [31:0] rpc;
      logic        stall;
      logic        aerr;
      logic [31:0] baddr;
      logic        nul;
   } exp_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_rpc;
   logic [31:0] exp_baddr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
      end
   endtask

   task automatic push(input logic r, input logic st, input logic ae, input logic nu);
      exp_t e;
      e.redirect = r;
      e.rpc      = exp_rpc;
      e.stall    = st;
      e.aerr     = ae;
      e.baddr    = exp_baddr;
      e.nul      = nu;
      sb.push_back(e);
   endtask

   // Advance one edge and compare every registered output against the oldest expectation.
   task automatic tick(input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s scoreboard empty observed=none expected=entry", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, ".redirect"},    32'(redirect),   32'(e.redirect));
         chk({tag, ".redirect_pc"}, redirect_pc,     e.rpc);
         chk({tag, ".stall_req"},   32'(stall_req),  32'(e.stall));
         chk({tag, ".addr_err"},    32'(addr_err),   32'(e.aerr));
         chk({tag, ".bad_addr"},    bad_addr,        e.baddr);
         chk({tag, ".nullify_ds"},  32'(nullify_ds), 32'(e.nul));
      end
   endtask

   task automatic br(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] pc, input logic [15:0] imm, input logic [25:0] idx,
                     input logic ds);
      br_valid   = 1'b1;
      br_op      = op;
      source_a   = a;
      source_b   = b;
      pc_id      = pc;
      imm16      = imm;
      index26    = idx;
      ds_fetched = ds;
      flush      = 1'b0;
   endtask

   task automatic quiet(input logic ds);
      br_valid   = 1'b0;
      ds_fetched = ds;
      flush      = 1'b0;
   endtask

   initial begin
      rst_n      = 1'b0;
      br_valid   = 1'b0;
      br_op      = '0;
      source_a   = '0;
      source_b   = '0;
      pc_id      = '0;
      imm16      = '0;
      index26    = '0;
      ds_fetched = 1'b0;
      flush      = 1'b0;
      exp_rpc    = RST_PC;
      exp_baddr  = '0;

      push(0, 0, 0, 0); tick("reset0");
      push(0, 0, 0, 0); tick("reset1");
      rst_n = 1'b1;
      quiet(0); push(0, 0, 0, 0); tick("idle");

      // BEQ taken with delay slot already fetched
      br(4'd0, 32'd5, 32'd5, 32'h8000_0100, 16'h0004, '0, 1'b1);
      #1;
      chk("beq.link_en",   32'(link_en), 32'd0);
      chk("beq.link_addr", link_addr,    32'h8000_0108);
      exp_rpc = 32'h8000_0114;
      push(1, 0, 0, 0); tick("beq");
      quiet(0); push(0, 0, 0, 0); tick("beq_after");

      // BNE taken, delay slot late by three cycles; a J in WAIT_DS must be ignored
      br(4'd1, 32'd1, 32'd2, 32'h8000_0200, 16'hFFF0, '0, 1'b0);
      push(0, 1, 0, 0); tick("bne_ws1");
      br(4'd8, 32'd0, 32'd0, 32'h8000_0000, 16'h0000, 26'h1, 1'b0);
      push(0, 1, 0, 0); tick("bne_ws2");
      quiet(0); push(0, 1, 0, 0); tick("bne_ws3");
      quiet(1);
      exp_rpc = 32'h8000_01C4;
      push(1, 0, 0, 0); tick("bne_issue");
      quiet(0); push(0, 0, 0, 0); tick("bne_after");

      // JALR to a misaligned target
      br(4'd11, 32'h8000_0202, 32'd0, 32'h8000_0000, 16'h0000, '0, 1'b1);
      #1;
      chk("jalr.link_en",   32'(link_en), 32'd1);
      chk("jalr.link_addr", link_addr,    32'h8000_0008);
      exp_baddr = 32'h8000_0202;
      push(0, 0, 1, 0); tick("jalr");
      quiet(0); push(0, 0, 0, 0); tick("jalr_after");

      // JAL where pc+4 crosses into a new 256 MB region
      br(4'd9, 32'd0, 32'd0, 32'h8FFF_FFFC, 16'h0000, 26'h2AB_CDEF, 1'b1);
      #1;
      chk("jal.link_en",   32'(link_en), 32'd1);
      chk("jal.link_addr", link_addr,    32'h9000_0004);
      exp_rpc = 32'h9AAF_37BC;
      push(1, 0, 0, 0); tick("jal");
      quiet(0); push(0, 0, 0, 0); tick("jal_after");

      // BLTZAL not taken still links
      br(4'd6, 32'd5, 32'd0, 32'h8000_0500, 16'h0004, '0, 1'b1);
      #1;
      chk("bltzal.link_en",   32'(link_en), 32'd1);
      chk("bltzal.link_addr", link_addr,    32'h8000_0508);
      push(0, 0, 0, 0); tick("bltzal");

      // BGEZ on the most negative value, then on zero with offset -4
      br(4'd5, 32'h8000_0000, 32'd0, 32'h8000_0300, 16'hFFFF, '0, 1'b1);
      push(0, 0, 0, 0); tick("bgez_neg");
      br(4'd5, 32'd0, 32'd0, 32'h8000_0300, 16'hFFFF, '0, 1'b1);
      exp_rpc = 32'h8000_0300;
      push(1, 0, 0, 0); tick("bgez_zero");
      quiet(0); push(0, 0, 0, 0); tick("bgez_after");

      // Flush while waiting for the delay slot, even with ds_fetched high
      br(4'd0, 32'd7, 32'd7, 32'h8000_0400, 16'h0001, '0, 1'b0);
      push(0, 1, 0, 0); tick("flush_ws");
      br_valid = 1'b0; ds_fetched = 1'b1; flush = 1'b1;
      push(0, 0, 0, 0); tick("flush_drop");
      quiet(1); push(0, 0, 0, 0); tick("flush_after");

      // Flush suppresses a misaligned JR error and an immediate taken branch
      br(4'd10, 32'h0000_1233, 32'd0, 32'h8000_0600, 16'h0000, '0, 1'b1);
      flush = 1'b1;
      push(0, 0, 0, 0); tick("flush_jr");
      br(4'd0, 32'd3, 32'd3, 32'h8000_0600, 16'h0010, '0, 1'b1);
      flush = 1'b1;
      push(0, 0, 0, 0); tick("flush_beq");
      quiet(0); push(0, 0, 0, 0); tick("flush_beq_after");

      // Reserved opcode with equal operands is not taken
      br(4'd14, 32'd9, 32'd9, 32'h8000_0700, 16'h0004, '0, 1'b1);
      push(0, 0, 0, 0); tick("reserved");

      // Likely branches: BEQL not taken, BNEL taken
      br(4'd12, 32'd1, 32'd2, 32'h8000_0800, 16'h0004, '0, 1'b1);
`ifdef BRC_LIKELY_EN
      push(0, 0, 0, 1);
`else
      push(0, 0, 0, 0);
`endif
      tick("beql_nt");
      quiet(0); push(0, 0, 0, 0); tick("beql_after");
      br(4'd13, 32'd1, 32'd2, 32'h8000_0800, 16'h0004, '0, 1'b1);
`ifdef BRC_LIKELY_EN
      exp_rpc = 32'h8000_0814;
      push(1, 0, 0, 0);
`else
      push(0, 0, 0, 0);
`endif
      tick("bnel_t");
      quiet(0); push(0, 0, 0, 0); tick("bnel_after");

      // Reset while waiting for the delay slot
      br(4'd1, 32'd1, 32'd2, 32'h8000_0900, 16'h0004, '0, 1'b0);
      push(0, 1, 0, 0); tick("rstmid_ws");
      rst_n = 1'b0;
      quiet(1);
      exp_rpc   = RST_PC;
      exp_baddr = '0;
      push(0, 0, 0, 0); tick("rstmid_reset");
      rst_n = 1'b1;
      quiet(1); push(0, 0, 0, 0); tick("rstmid_after");

      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/brcunit.md
# brcunit

Branch resolution unit in the ID stage, directly downstream of the branch operand select (forwarded `source_a`/`source_b`). It evaluates the branch/jump condition, computes the target and link address, and drives a registered one-cycle redirect to IF. Redirect is deferred until the delay-slot instruction has been fetched. It also raises a stall while waiting for that delay slot, and flags misaligned register-jump targets.

## Interface
Parameters:
- `RESET_PC`, 32'hBFC0_0000: value of `redirect_pc` and the latched target at reset.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `br_valid`  in  1  branch/jump instruction valid in ID and ID not stalled this cycle.
- `br_op`  in  4  0 BEQ, 1 BNE, 2 BLEZ, 3 BGTZ, 4 BLTZ, 5 BGEZ, 6 BLTZAL, 7 BGEZAL, 8 J, 9 JAL, 10 JR, 11 JALR, 12 BEQL, 13 BNEL, 14–15 reserved (treated as not-taken).
- `source_a`  in  32  rs operand, already forwarded.
- `source_b`  in  32  rt operand, already forwarded.
- `pc_id`  in  32  PC of the branch instruction.
- `imm16`  in  16  branch offset.
- `index26`  in  26  jump index.
- `ds_fetched`  in  1  delay-slot instruction accepted into IF/ID (level).
- `flush`  in  1  exception/ERET flush.
- `redirect`  out  1  one-cycle pulse; IF loads `redirect_pc`.
- `redirect_pc`  out  32  target address.
- `link_en`  out  1  combinational; link write required (6, 7, 9, 11 when `br_valid`).
- `link_addr`  out  32  `pc_id + 8`.
- `stall_req`  out  1  hold IF/ID while waiting for the delay slot.
- `addr_err`  out  1  one-cycle pulse; JR/JALR target not word-aligned.
- `bad_addr`  out  32  offending target, held until the next `addr_err`.
- `nullify_ds`  out  1  one-cycle pulse; squash the delay slot (likely branches only).

## Operation
- Conditions:
  - Signed compares on `source_a` (BLEZ: a≤0, BGTZ: a>0, BLTZ/BLTZAL: a<0, BGEZ/BGEZAL: a≥0).
  - BEQ/BNE and the -L forms compare a against b.
  - J/JAL/JR/JALR are always taken.
- Targets, all modulo 2^32:
  - Branches: `pc_id + 4 + (sext(imm16) << 2)`.
  - J/JAL: `{(pc_id+4)[31:28], index26, 2'b00}`.
  - JR/JALR: `source_a`.
- Link: `link_addr = pc_id + 8`. Link is written even when a linking branch is not taken.
- FSM states IDLE, WAIT_DS, ISSUE.
  - IDLE:
    - `br_valid` & taken & target[1:0]==0: latch target. If `ds_fetched`, go to ISSUE; else go to WAIT_DS.
    - `br_valid` & JR/JALR & target[1:0]≠0: pulse `addr_err` next cycle, latch `bad_addr`, stay in IDLE, no redirect.
  - WAIT_DS: `stall_req`=1. On `ds_fetched`, go to ISSUE.
  - ISSUE: `redirect`=1 for exactly this cycle, then go to IDLE.
- `br_valid` in WAIT_DS or ISSUE is ignored. A branch in a delay slot is architecturally undefined.
- `flush` in any state: go to IDLE next cycle. It suppresses the redirect, `addr_err`, and `nullify_ds` that would otherwise assert in that next cycle. `flush` has priority over all other events.
- `redirect_pc` holds its last value when `redirect`=0.

## Timing
- Reset values: state IDLE; `redirect`, `stall_req`, `addr_err`, `nullify_ds` = 0; `redirect_pc` = `RESET_PC`; `bad_addr` = 0.
- Redirect latency, resolution cycle N:
  - If `ds_fetched` at N: `redirect` at N+1.
  - Otherwise: `redirect` the cycle after the first cycle `ds_fetched`=1.
- `stall_req` is registered and asserted for every cycle spent in WAIT_DS.
- `addr_err` and `nullify_ds` assert at N+1.
- `link_en` and `link_addr` are combinational in cycle N.
- Reset mid-operation (WAIT_DS or ISSUE) returns to IDLE with no redirect.

## Configuration
- `BRC_LIKELY_EN`:
  - Defined: ops 12/13 are decoded. A not-taken likely branch pulses `nullify_ds` at N+1 and never redirects. A taken one behaves as BEQ/BNE.
  - Undefined: ops 12/13 are treated as reserved (not taken), and `nullify_ds` is tied to 0.

## Test plan
- BEQ: `pc_id`=0x8000_0100, a=b=5, imm16=0x0004, `ds_fetched`=1 → `redirect` at N+1, `redirect_pc`=0x8000_0114, `stall_req` never 1.
- BNE taken, `ds_fetched` low for 3 cycles → `stall_req`=1 for 3 cycles, `redirect` the cycle after `ds_fetched` rises, with the correct target.
- JALR: a=0x8000_0202, `pc_id`=0x8000_0000 → `link_en`=1, `link_addr`=0x8000_0008, `addr_err` pulse, `bad_addr`=0x8000_0202, no redirect.
- BGEZ: a=0x8000_0000 (negative), imm16=0xFFFF → not taken, no redirect. Same branch with a=0 → `redirect_pc`=`pc_id` (offset −4 +4).
- `flush` asserted in WAIT_DS → IDLE next cycle, `redirect` stays 0, `stall_req` drops.
- With `BRC_LIKELY_EN`: BEQL with a=1, b=2 → `nullify_ds` pulse at N+1, no redirect. Without the macro: no pulse.
